// File: rtl/fmcomms5_ctrl_pkg.sv
// Shared constants for the FMCOMMS5 control/status slave: register map,
// bit positions, reset defaults and FSM state encodings.
package fmcomms5_ctrl_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h464D_4335;  // "FMC5"

  // Register index = addr[4:2]
  localparam logic [2:0] REG_ID          = 3'd0;
  localparam logic [2:0] REG_SCRATCH     = 3'd1;
  localparam logic [2:0] REG_CTRL        = 3'd2;
  localparam logic [2:0] REG_SYNC_CMD    = 3'd3;
  localparam logic [2:0] REG_SYNC_PERIOD = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;
  localparam logic [2:0] REG_SYNC_COUNT  = 3'd6;
  localparam logic [2:0] REG_RSVD        = 3'd7;

  localparam int CTRL_EN0      = 0;
  localparam int CTRL_TXNRX0   = 1;
  localparam int CTRL_EN1      = 2;
  localparam int CTRL_TXNRX1   = 3;
  localparam int CTRL_PERIODIC = 8;
  localparam logic [31:0] CTRL_MASK = 32'h0000_010F;

  localparam int ST_BUSY     = 0;
  localparam int ST_EXT_SEEN = 1;
  localparam int ST_DROPPED  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;
  typedef enum logic { S_IDLE, S_PULSE } s_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdat[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/fmcomms5_ctrl_if.sv
// AXI4-Lite bundle (32-bit address/data) with master and slave views.
interface fmcomms5_ctrl_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fmcomms5_sync_pulse_gen.sv
// TDD sync pulse generator: merges command and periodic triggers, times the
// pulse, counts pulses and flags triggers that arrive while a pulse is active.
module fmcomms5_sync_pulse_gen
  import fmcomms5_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_trig,
  input  logic        periodic,
  input  logic [31:0] period,
  input  logic [31:0] period_nxt,
  input  logic        reload,
  input  logic        drop_clr,
  output logic        pulse,
  output logic        busy,
  output logic        dropped,
  output logic [31:0] count
);

  localparam logic [7:0] PW_LAST = 8'(PULSE_CYCLES - 1);

  s_state_e    state_q;
  logic        pulse_q;
  logic [7:0]  wcnt_q;
  logic [31:0] count_q;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic        dropped_q, dropped_d;
  logic        expire, trig;

  // Reload uses the value SYNC_PERIOD takes on this same edge.
  always_comb begin
    per_cnt_d = per_cnt_q;
    expire    = 1'b0;
    if (reload) begin
      per_cnt_d = period_nxt - 32'd1;
    end else if (periodic && period != 32'd0) begin
      if (per_cnt_q == 32'd0) begin
        expire    = 1'b1;
        per_cnt_d = period - 32'd1;
      end else begin
        per_cnt_d = per_cnt_q - 32'd1;
      end
    end
  end

  assign trig = cmd_trig | expire;

  // Set wins over a same-cycle clear.
  always_comb begin
    dropped_d = dropped_q;
    if (drop_clr) dropped_d = 1'b0;
    if (trig && state_q == S_PULSE) dropped_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= 32'd0;
      dropped_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pulse_q <= 1'b0;
      wcnt_q  <= 8'd0;
      count_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (trig) begin
          state_q <= S_PULSE;
          pulse_q <= 1'b1;
          wcnt_q  <= PW_LAST;
          count_q <= count_q + 32'd1;
        end
        S_PULSE: if (wcnt_q == 8'd0) begin
          state_q <= S_IDLE;
          pulse_q <= 1'b0;
        end else begin
          wcnt_q <= wcnt_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pulse   = pulse_q;
  assign busy    = (state_q == S_PULSE);
  assign dropped = dropped_q;
  assign count   = count_q;

endmodule

// File: rtl/fmcomms5_ctrl_regs.sv
// AXI4-Lite control/status slave for the dual AD9361 FMCOMMS5 setup: ENSM/TXNRX
// controls, TDD sync pulse generation and sync-output observation.
module fmcomms5_ctrl_regs
  import fmcomms5_ctrl_pkg::*;
#(
  parameter logic [31:0] ID_VALUE          = ID_DEFAULT,
  parameter int          SYNC_PULSE_CYCLES = 8,
  parameter logic [31:0] PERIOD_RESET      = 32'd0
) (
  input  logic           axi_aclk,
  input  logic           axi_aresetn,
  fmcomms5_ctrl_if.slave s_axi,
  output logic           up_enable_0,
  output logic           up_txnrx_0,
  output logic           up_enable_1,
  output logic           up_txnrx_1,
  output logic           tdd_sync_i,
  input  logic           tdd_sync_0_o,
  input  logic           tdd_sync_1_o
);

  w_state_e    w_state_q;
  logic        aw_rdy_q, bvalid_q;
  r_state_e    r_state_q;
  logic        ar_rdy_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;

  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] period_q, period_d;
  logic        ext_seen_q, ext_seen_d;
  logic        ext_meta_q, ext_sync_q, ext_prev_q, ext_rise;
  logic        cmd_trig, drop_clr, reload;
  logic        pulse, busy, dropped;
  logic [31:0] sync_count;
  logic        unused_ok;

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[31:5], s_axi.awaddr[1:0],
                       s_axi.araddr[31:5], s_axi.araddr[1:0]};

  // awready/wready pulse together; the handshake edge is the register write edge.
  assign wr_en  = aw_rdy_q & s_axi.awvalid & s_axi.wvalid;
  assign wr_idx = s_axi.awaddr[4:2];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_rdy_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_rdy_q) begin
          aw_rdy_q <= 1'b0;
          if (s_axi.awvalid && s_axi.wvalid) begin
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end else if (s_axi.awvalid && s_axi.wvalid) begin
          aw_rdy_q <= 1'b1;
        end
        W_RESP: if (s_axi.bready) begin
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (s_axi.araddr[4:2])
      REG_ID:          rd_mux = ID_VALUE;
      REG_SCRATCH:     rd_mux = scratch_q;
      REG_CTRL:        rd_mux = ctrl_q;
      REG_SYNC_PERIOD: rd_mux = period_q;
      REG_STATUS: begin
        rd_mux[ST_BUSY]     = busy;
        rd_mux[ST_EXT_SEEN] = ext_seen_q;
        rd_mux[ST_DROPPED]  = dropped;
      end
      REG_SYNC_COUNT:         rd_mux = sync_count;
      REG_SYNC_CMD, REG_RSVD: rd_mux = 32'd0;
      default:                rd_mux = 32'd0;
    endcase
  end

  // rdata samples pre-edge register values, so a same-edge write reads old data.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state_q <= R_IDLE;
      ar_rdy_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_rdy_q) begin
          ar_rdy_q <= 1'b0;
          if (s_axi.arvalid) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
            r_state_q <= R_RESP;
          end
        end else if (s_axi.arvalid) begin
          ar_rdy_q <= 1'b1;
        end
        R_RESP: if (s_axi.rready) begin
          rvalid_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = aw_rdy_q;
  assign s_axi.wready  = aw_rdy_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = ar_rdy_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign ext_rise = ext_sync_q & ~ext_prev_q;

  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    ext_seen_d = ext_seen_q;
    if (wr_en) begin
      case (wr_idx)
        REG_SCRATCH:     scratch_d = apply_strb(scratch_q, s_axi.wdata, s_axi.wstrb);
        REG_CTRL:        ctrl_d    = apply_strb(ctrl_q, s_axi.wdata, s_axi.wstrb) & CTRL_MASK;
        REG_SYNC_PERIOD: period_d  = apply_strb(period_q, s_axi.wdata, s_axi.wstrb);
        REG_STATUS: if (s_axi.wstrb[0] && s_axi.wdata[ST_EXT_SEEN]) ext_seen_d = 1'b0;
        default: ;
      endcase
    end
    if (ext_rise) ext_seen_d = 1'b1;
  end

  assign cmd_trig = wr_en && wr_idx == REG_SYNC_CMD && s_axi.wstrb[0] && s_axi.wdata[0];
  assign drop_clr = wr_en && wr_idx == REG_STATUS && s_axi.wstrb[0] && s_axi.wdata[ST_DROPPED];
  assign reload   = wr_en && (wr_idx == REG_SYNC_PERIOD || (wr_idx == REG_CTRL && s_axi.wstrb[1]));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      scratch_q  <= 32'd0;
      ctrl_q     <= 32'd0;
      period_q   <= PERIOD_RESET;
      ext_seen_q <= 1'b0;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      ext_seen_q <= ext_seen_d;
      ext_meta_q <= tdd_sync_0_o | tdd_sync_1_o;
      ext_sync_q <= ext_meta_q;
      ext_prev_q <= ext_sync_q;
    end
  end

  fmcomms5_sync_pulse_gen #(
    .PULSE_CYCLES(SYNC_PULSE_CYCLES)
  ) u_sync (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .cmd_trig  (cmd_trig),
    .periodic  (ctrl_q[CTRL_PERIODIC]),
    .period    (period_q),
    .period_nxt(period_d),
    .reload    (reload),
    .drop_clr  (drop_clr),
    .pulse     (pulse),
    .busy      (busy),
    .dropped   (dropped),
    .count     (sync_count)
  );

  assign up_enable_0 = ctrl_q[CTRL_EN0];
  assign up_txnrx_0  = ctrl_q[CTRL_TXNRX0];
  assign up_enable_1 = ctrl_q[CTRL_EN1];
  assign up_txnrx_1  = ctrl_q[CTRL_TXNRX1];
  assign tdd_sync_i  = pulse;

endmodule

// File: tb/tb_fmcomms5_ctrl_regs.sv
// Directed bench for fmcomms5_ctrl_regs: register access, CTRL outputs, one-shot
// and periodic sync pulses, W1C status, backpressure and asynchronous reset.
module tb_fmcomms5_ctrl_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_en0, up_tx0, up_en1, up_tx1, tdd_sync;
  logic ext0 = 1'b0, ext1 = 1'b0;
  int   checks = 0, failures = 0;

  fmcomms5_ctrl_if axi();

  fmcomms5_ctrl_regs dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .s_axi       (axi),
    .up_enable_0 (up_en0),
    .up_txnrx_0  (up_tx0),
    .up_enable_1 (up_en1),
    .up_txnrx_1  (up_tx1),
    .tdd_sync_i  (tdd_sync),
    .tdd_sync_0_o(ext0),
    .tdd_sync_1_o(ext1)
  );

  always #5 clk = ~clk;

  // Pulse monitor: rise timestamps and width of the last completed pulse.
  longint cyc = 0, last_rise = 0, prev_rise = 0;
  int     rise_cnt = 0, hi_cnt = 0, last_width = 0;
  logic   prev_s = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tdd_sync) begin
      if (!prev_s) begin
        rise_cnt++;
        prev_rise = last_rise;
        last_rise = cyc;
        hi_cnt    = 1;
      end else hi_cnt++;
    end else if (prev_s) last_width = hi_cnt;
    prev_s = tdd_sync;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic aw_wait_ready(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while (!axi.awready && n < 20) begin @(posedge clk); #1; n++; end
    chk("aw_w_ready", {30'd0, axi.wready, axi.awready}, 32'd3);
  endtask

  task automatic aw_fire();
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("bvalid_after_hs", {31'd0, axi.bvalid}, 32'd1);
  endtask

  task automatic b_accept();
    chk("bresp", {30'd0, axi.bresp}, 32'd0);
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_wait_ready(a, d, s);
    aw_fire();
    b_accept();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!axi.arready && n < 20) begin @(posedge clk); #1; n++; end
    chk("arready", {31'd0, axi.arready}, 32'd1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    chk("rvalid", {31'd0, axi.rvalid}, 32'd1);
    chk("rresp", {30'd0, axi.rresp}, 32'd0);
    chk(tag, axi.rdata, exp);
    axi.rready = 1'b1;
    @(posedge clk); #1;
    axi.rready = 1'b0;
  endtask

  initial begin
    int n;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // 1. Reset state and ID
    #12;
    chk("reset_outs", {23'd0, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
                       up_en0, up_tx0, up_en1, up_tx1, tdd_sync}, 32'd0);
    chk("reset_rdata", axi.rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    read_chk("id", 32'h00, 32'h464D_4335);

    // 2. CTRL drives up_* after the handshake edge; wstrb=0 leaves it alone
    aw_wait_ready(32'h08, 32'h0F, 4'h1);
    chk("up_before_hs", {28'd0, up_tx1, up_en1, up_tx0, up_en0}, 32'h0);
    aw_fire();
    chk("up_after_hs", {28'd0, up_tx1, up_en1, up_tx0, up_en0}, 32'hF);
    b_accept();
    axi_write(32'h08, 32'h00, 4'h0);
    chk("up_strb0", {28'd0, up_tx1, up_en1, up_tx0, up_en0}, 32'hF);
    read_chk("ctrl_rd", 32'h08, 32'h0000_000F);
    axi_write(32'h04, 32'hDEAD_BEEF, 4'b0101);
    read_chk("scratch_strb", 32'h04, 32'h00AD_00EF);

    // 3. One-shot pulse
    axi_write(32'h0C, 32'h1, 4'h1);
    read_chk("status_busy", 32'h14, 32'h1);
    repeat (12) @(posedge clk); #1;
    chk("oneshot_width", last_width, 32'd8);
    chk("oneshot_rises", rise_cnt, 32'd1);
    read_chk("sync_count1", 32'h18, 32'd1);
    read_chk("status_idle", 32'h14, 32'h0);
    read_chk("sync_cmd_rd", 32'h0C, 32'h0);

    // 4. Periodic pulses, dropped trigger, W1C clear
    axi_write(32'h10, 32'd100, 4'hF);
    axi_write(32'h08, 32'h10F, 4'b0011);
    n = 0;
    while (rise_cnt < 3 && n < 400) begin @(posedge clk); #1; n++; end
    chk("periodic_rises", rise_cnt, 32'd3);
    chk("period_spacing", 32'(last_rise - prev_rise), 32'd100);
    chk("in_pulse", {31'd0, tdd_sync}, 32'd1);
    axi_write(32'h0C, 32'h1, 4'h1);
    begin
      int v;
      axi.araddr = 32'h14; axi.arvalid = 1'b1;
      n = 0;
      while (!axi.arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      v = axi.rdata;
      chk("dropped_set", {31'd0, v[2]}, 32'd1);
      axi.rready = 1'b1; @(posedge clk); #1; axi.rready = 1'b0;
    end
    axi_write(32'h14, 32'h4, 4'h1);
    axi_write(32'h08, 32'h0F, 4'b0011);
    chk("up_after_periodic_off", {28'd0, up_tx1, up_en1, up_tx0, up_en0}, 32'hF);
    repeat (150) @(posedge clk); #1;
    read_chk("dropped_clr", 32'h14, 32'h0);
    chk("no_more_rises", rise_cnt, 32'd3);
    chk("periodic_width", last_width, 32'd8);
    read_chk("sync_count3", 32'h18, 32'd3);

    // 5. B-channel backpressure blocks a queued write
    aw_wait_ready(32'h04, 32'h1122_3344, 4'hF);
    aw_fire();
    axi.awaddr = 32'h04; axi.wdata = 32'h55; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bvalid_held", {31'd0, axi.bvalid}, 32'd1);
      chk("aw_blocked", {31'd0, axi.awready}, 32'd0);
    end
    axi.bready = 1'b1; @(posedge clk); #1; axi.bready = 1'b0;
    chk("bvalid_drop", {31'd0, axi.bvalid}, 32'd0);
    axi_write(32'h04, 32'h55, 4'hF);
    read_chk("scratch_queued", 32'h04, 32'h55);
    read_chk("rsvd_1c", 32'h1C, 32'h0);

    // 6. External sync observation and reset mid-pulse
    ext1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    ext1 = 1'b0;
    repeat (4) @(posedge clk); #1;
    read_chk("ext_seen", 32'h14, 32'h2);
    axi_write(32'h14, 32'h2, 4'h1);
    read_chk("ext_clr", 32'h14, 32'h0);
    axi_write(32'h10, 32'd40, 4'hF);
    aw_wait_ready(32'h0C, 32'h1, 4'h1);
    aw_fire();
    chk("pulse_before_rst", {31'd0, tdd_sync}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {27'd0, axi.bvalid, up_en0, up_tx0, up_en1, tdd_sync}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_chk("count_after_rst", 32'h18, 32'd0);
    read_chk("period_after_rst", 32'h10, 32'd0);
    read_chk("ctrl_after_rst", 32'h08, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
